// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, port owners, request kinds.
// No logic, no latency, no backpressure.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } kind_e;

endpackage

// File: rtl/mem_req_slot.sv
// One-entry request latch with full flag; load wins over clear so a new request can land on the completion edge.
// Contents visible one cycle after load; the owner gates load with full, so the slot never overwrites live data.
module mem_req_slot
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit WRITABLE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_wdata,
    input  logic [DATA_W/8-1:0] ld_wmask,
    input  kind_e               ld_kind,
    output logic                full,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wmask,
    output kind_e               kind
);

    logic                full_q,  full_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    kind_e               kind_q,  kind_d;

    always_comb begin
        full_d  = full_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        kind_d  = kind_q;
        if (load) begin
            full_d  = 1'b1;
            addr_d  = ld_addr;
            // A read-only slot never carries write payload, whatever the caller drives.
            wdata_d = WRITABLE ? ld_wdata : '0;
            wmask_d = WRITABLE ? ld_wmask : '0;
            kind_d  = WRITABLE ? ld_kind  : RD;
        end else if (clr) begin
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            kind_q  <= RD;
        end else begin
            full_q  <= full_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            kind_q  <= kind_d;
        end
    end

    assign full  = full_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign wmask = wmask_q;
    assign kind  = kind_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises an instruction read port and a data read/write port onto one strobe/busy memory port, round-robin.
// Strobe N -> issue N+1 -> port busy low N+3 with zero-wait memory; each memory busy cycle adds one; a strobe while busy is dropped.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit PRIO_D = 1'b1
) (
    input  logic                rst,
    input  logic                clk,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_rstrb,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rbusy,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic                d_wstrb,
    input  logic                d_rstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rbusy,
    output logic                d_wbusy,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic                m_rstrb,
    output logic                m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_rbusy,
    input  logic                m_wbusy
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e rr_last_q, rr_last_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic                i_full, d_full;
    logic [ADDR_W-1:0]   i_s_addr, d_s_addr;
    logic [DATA_W-1:0]   i_s_wdata, d_s_wdata;
    logic [DATA_W/8-1:0] i_s_wmask, d_s_wmask;
    kind_e               i_s_kind, d_s_kind;

    logic                i_load, d_load, i_clr, d_clr;
    logic                i_avail, d_avail, done, sel_busy;
    kind_e               d_kind_in, own_kind;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic [DATA_W/8-1:0] own_wmask;

    assign own_addr  = (owner_q == OWN_D) ? d_s_addr  : i_s_addr;
    assign own_wdata = (owner_q == OWN_D) ? d_s_wdata : i_s_wdata;
    assign own_wmask = (owner_q == OWN_D) ? d_s_wmask : i_s_wmask;
    assign own_kind  = (owner_q == OWN_D) ? d_s_kind  : i_s_kind;

    assign sel_busy = (own_kind == RD) ? m_rbusy : m_wbusy;
    assign done     = (state_q == WAIT) && !sel_busy;
    assign i_clr    = done && (owner_q == OWN_I);
    assign d_clr    = done && (owner_q == OWN_D);

    // A strobe landing on the completion edge refills the slot instead of being lost.
    assign i_load    = i_rstrb && (!i_full || i_clr);
    assign d_load    = (d_rstrb || d_wstrb) && (!d_full || d_clr);
    assign d_kind_in = d_wstrb ? WR : RD;

    // Arbitration looks at this cycle's loads too, so an idle arbiter issues on the very next cycle.
    assign i_avail = i_full || i_load;
    assign d_avail = d_full || d_load;

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRITABLE(1'b0)) u_i_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (i_load),
        .clr      (i_clr),
        .ld_addr  (i_addr),
        .ld_wdata ('0),
        .ld_wmask ('0),
        .ld_kind  (RD),
        .full     (i_full),
        .addr     (i_s_addr),
        .wdata    (i_s_wdata),
        .wmask    (i_s_wmask),
        .kind     (i_s_kind)
    );

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRITABLE(1'b1)) u_d_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (d_load),
        .clr      (d_clr),
        .ld_addr  (d_addr),
        .ld_wdata (d_wdata),
        .ld_wmask (d_wmask),
        .ld_kind  (d_kind_in),
        .full     (d_full),
        .addr     (d_s_addr),
        .wdata    (d_s_wdata),
        .wmask    (d_s_wmask),
        .kind     (d_s_kind)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            rr_last_q <= PRIO_D ? OWN_I : OWN_D;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            IDLE: begin
                if (i_avail || d_avail) begin
                    state_d = ISSUE;
                    if (i_avail && d_avail) begin
                        owner_d = (rr_last_q == OWN_I) ? OWN_D : OWN_I;
                    end else if (d_avail) begin
                        owner_d = OWN_D;
                    end else begin
                        owner_d = OWN_I;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (done) begin
                    state_d   = IDLE;
                    rr_last_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_addr    = '0;
        m_wdata   = '0;
        m_wmask   = '0;
        m_rstrb   = 1'b0;
        m_wstrb   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (state_q != IDLE) begin
            m_addr = own_addr;
            if (own_kind == WR) begin
                m_wdata = own_wdata;
                m_wmask = own_wmask;
            end
        end
        if (state_q == ISSUE) begin
            m_rstrb = (own_kind == RD);
            m_wstrb = (own_kind == WR);
        end
        if (done && own_kind == RD) begin
            if (owner_q == OWN_I) i_rdata_d = m_rdata;
            else                  d_rdata_d = m_rdata;
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_rbusy = i_full;
    assign d_rbusy = d_full && (d_s_kind == RD);
    assign d_wbusy = d_full && (d_s_kind == WR);

endmodule
